// File: rtl/instr_fifo_pkg.sv
// Shared types and constants for the decode-to-issue instruction queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package instr_fifo_pkg;

    // Default number of queue entries. Must be a power of two and at least 4.
    localparam int INSTR_FIFO_DEPTH = 16;

    // One decoded instruction, together with its branch prediction.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fifo_entry_t;

endpackage

// File: rtl/instr_fifo_ram.sv
// Entry storage for instr_fifo: DEPTH x fifo_entry_t, two write ports and two async read ports.
// Latency: a write lands at the clock edge; reads are combinational from the current contents.
// Backpressure: none; the caller never writes both ports to the same address in one cycle.
module instr_fifo_ram
    import instr_fifo_pkg::*;
#(
    parameter  int DEPTH = INSTR_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we0,
    input  logic [PTR_W-1:0]  waddr0,
    input  fifo_entry_t       wdata0,
    input  logic              we1,
    input  logic [PTR_W-1:0]  waddr1,
    input  fifo_entry_t       wdata1,
    input  logic [PTR_W-1:0]  raddr0,
    input  logic [PTR_W-1:0]  raddr1,
    output fifo_entry_t       rdata0,
    output fifo_entry_t       rdata1
);

    // The contents are not reset; only the pointers in the parent mark entries as valid.
    fifo_entry_t mem [DEPTH];

    // Both write ports commit on the same edge.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[waddr0] <= wdata0;
        end
        if (we1) begin
            mem[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/instr_fifo.sv
// Two-wide in, two-wide out instruction queue between decode and issue; define INSTR_FIFO_BYPASS_EN for an empty-queue bypass.
// Latency: a push is first visible the next cycle (or the same cycle when the bypass is built in and the queue is empty).
// Backpressure: a push that does not fit is dropped whole; overflow warns decode while fewer than two entries are free.
module instr_fifo
    import instr_fifo_pkg::*;
#(
    parameter  int DEPTH = INSTR_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             push_valid,
    input  fifo_entry_t [1:0]      push_data,
    input  logic [1:0]             pop_ready,
    input  logic                   stall_de,
    input  logic                   flush,
    input  logic                   pred_flush,
    output logic [1:0]             pop_valid,
    output fifo_entry_t [1:0]      pop_data,
    output logic                   overflow,
    output logic [PTR_W:0]         count
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             flush_any;
    logic             byp_active;
    logic [CNT_W-1:0] free_slots;
    logic [1:0]       n_push;
    logic [1:0]       n_acc;
    logic [1:0]       n_pop;
    logic [1:0]       n_skip;
    logic [1:0]       n_wr;
    logic             push_ok;

    logic             we0, we1;
    logic [PTR_W-1:0] waddr0, waddr1;
    fifo_entry_t      wdata0, wdata1;
    fifo_entry_t      rd_dat0, rd_dat1;

    instr_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we0    (we0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .raddr0 (head_q),
        .raddr1 (head_q + PTR_W'(1)),
        .rdata0 (rd_dat0),
        .rdata1 (rd_dat1)
    );

    // Head-of-queue view; with the bypass built in, an empty queue shows the incoming pushes directly.
    always_comb begin
        flush_any  = flush | pred_flush;
        byp_active = 1'b0;
`ifdef INSTR_FIFO_BYPASS_EN
        byp_active = (count_q == '0) && !flush_any;
`endif
        if (byp_active) begin
            pop_valid = push_valid;
            pop_data  = push_data;
        end else begin
            pop_valid[0] = (count_q >= CNT_W'(1)) && !flush_any;
            pop_valid[1] = (count_q >= CNT_W'(2)) && !flush_any;
            pop_data[0]  = rd_dat0;
            pop_data[1]  = rd_dat1;
        end
    end

    // Push acceptance is judged against the occupancy before any same-cycle pop, so a full queue
    // drops a double push even while issue takes two.
    always_comb begin
        free_slots = CNT_W'(DEPTH) - count_q;
        n_push     = {1'b0, push_valid[0]} + {1'b0, push_valid[1]};
        push_ok    = !flush_any && (free_slots >= CNT_W'(n_push));
        n_acc      = push_ok ? n_push : 2'd0;
        overflow   = free_slots < CNT_W'(2);
    end

    // Issue takes two only when both slots are offered and valid; slot1 alone never leaves.
    always_comb begin
        if (stall_de) begin
            n_pop = 2'd0;
        end else if ((pop_ready == 2'b11) && (pop_valid == 2'b11)) begin
            n_pop = 2'd2;
        end else if (pop_ready[0] && pop_valid[0]) begin
            n_pop = 2'd1;
        end else begin
            n_pop = 2'd0;
        end
    end

    // Write-port steering; entries consumed straight off the bypass are skipped, the rest land at tail.
    always_comb begin
        n_skip = byp_active ? n_pop : 2'd0;
        n_wr   = n_acc - n_skip;
        we0    = !reset && (n_wr != 2'd0);
        we1    = !reset && (n_wr == 2'd2);
        waddr0 = tail_q;
        waddr1 = tail_q + PTR_W'(1);
        // A lone slot1 push (not expected from decode) is still written as the oldest new entry.
        if ((n_skip == 2'd1) || !push_valid[0]) begin
            wdata0 = push_data[1];
        end else begin
            wdata0 = push_data[0];
        end
        wdata1 = push_data[1];
    end

    // Next pointers and occupancy; any flush empties the queue and discards this cycle's traffic.
    always_comb begin
        if (flush_any) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + (byp_active ? PTR_W'(0) : PTR_W'(n_pop));
            tail_d  = tail_q + PTR_W'(n_wr);
            count_d = count_q + CNT_W'(n_acc) - CNT_W'(n_pop);
        end
    end

    // State registers; reset outranks flush, push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
